// File: rtl/plot_writer.sv
// plot_writer: consumer end of the pixel-plot interface.
// Takes one (x, y, colour) request per cycle into a small FIFO, drops
// off-screen coordinates with a one-cycle reject pulse, and drains queued
// pixels into the frame-buffer write port at address y*160 + x, stalling
// whenever the RAM reports busy.
module plot_writer #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [7:0]  VGA_x,
    input  logic [6:0]  VGA_y,
    input  logic [2:0]  VGA_Colour,
    output logic        ready,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        fb_we,
    input  logic        fb_busy,
    output logic [4:0]  count,
    output logic        reject,
    output logic        idle
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 15 + 3;

    // Each FIFO slot holds the precomputed address next to the colour so the
    // drain side needs no arithmetic.
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic [14:0]      fb_addr_q, fb_addr_d;
    logic [2:0]       fb_data_q, fb_data_d;
    logic             fb_we_q, fb_we_d;
    logic             reject_q, reject_d;
    logic             idle_q, idle_d;

    logic             accept;
    logic             in_range;
    logic             push;
    logic             pop;
    logic [14:0]      addr_in;
    logic [ENTRY_W-1:0] head;

    // ready looks only at the registered occupancy: a pop in the same cycle
    // does not open a slot until the following cycle.
    assign ready = (count_q != 5'(DEPTH));

    // Row base y*160 is built as y*128 + y*32 so no multiplier is needed.
    assign addr_in = 15'({VGA_y, 7'b0}) + 15'({VGA_y, 5'b0}) + 15'(VGA_x);

    assign head = mem[rd_ptr_q];

    // Decode the accept/push/pop decisions for this cycle.
    always_comb begin
        accept   = plot && ready;
        in_range = (32'(VGA_x) < SCREEN_W) && (32'(VGA_y) < SCREEN_H);
        push     = accept && in_range;
        // Pop only from entries already registered, so a fresh push into an
        // empty FIFO waits one edge before it can drain.
        pop      = (count_q != 5'd0) && !fb_busy;
    end

    // Next-state computation for pointers, occupancy and write-port outputs.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        fb_we_d   = 1'b0;
        reject_d  = accept && !in_range;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            fb_addr_d = head[ENTRY_W-1:3];
            fb_data_d = head[2:0];
            fb_we_d   = 1'b1;
        end

        count_d = count_q + 5'(push) - 5'(pop);
        idle_d  = (count_d == 5'd0) && !fb_we_d;
    end

    // FIFO storage: written only on push; not reset since the pointers and
    // count define which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {addr_in, VGA_Colour};
        end
    end

    // Control and output registers; reset clears everything at once so no
    // write can leak out after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 5'd0;
            fb_addr_q <= 15'd0;
            fb_data_q <= 3'd0;
            fb_we_q   <= 1'b0;
            reject_q  <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            fb_we_q   <= fb_we_d;
            reject_q  <= reject_d;
            idle_q    <= idle_d;
        end
    end

    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;
    assign fb_we   = fb_we_q;
    assign count   = count_q;
    assign reject  = reject_q;
    assign idle    = idle_q;

endmodule

// File: tb/tb_plot_writer.sv
// Scoreboard bench for plot_writer: stimulus pushes expected writes into a
// queue, an independent monitor pops and compares on every fb_we.
module tb_plot_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        plot;
    logic [7:0]  VGA_x;
    logic [6:0]  VGA_y;
    logic [2:0]  VGA_Colour;
    logic        ready;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_busy;
    logic [4:0]  count;
    logic        reject;
    logic        idle;

    int checks   = 0;
    int failures = 0;
    int writes   = 0;
    int rejects  = 0;
    int ready_drops = 0;
    logic [14:0] last_addr = '0;
    logic [17:0] exp_q [$];

    plot_writer dut (
        .clk        (clk),
        .reset      (reset),
        .plot       (plot),
        .VGA_x      (VGA_x),
        .VGA_y      (VGA_y),
        .VGA_Colour (VGA_Colour),
        .ready      (ready),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .fb_busy    (fb_busy),
        .count      (count),
        .reject     (reject),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (reject) rejects++;
            if (fb_we) begin
                writes++;
                last_addr = fb_addr;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write actual=addr %0d data %0d required=no write",
                             fb_addr, fb_data);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    if ({fb_addr, fb_data} != e) begin
                        failures++;
                        $display("FAIL write_order actual=addr %0d data %0d required=addr %0d data %0d",
                                 fb_addr, fb_data, e[17:3], e[2:0]);
                    end
                end
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following
    // the edge at which the request was accepted.
    task automatic send(input int x, input int y, input int c);
        int guard;
        plot       = 1'b1;
        VGA_x      = 8'(x);
        VGA_y      = 7'(y);
        VGA_Colour = 3'(c);
        guard      = 0;
        while (!ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) check("send_timeout", 0, 1);
        if (x < 160 && y < 120) exp_q.push_back({15'(y * 160 + x), 3'(c)});
        @(negedge clk);
        plot = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((count != 0 || exp_q.size() != 0) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check(name, int'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; plot = 1'b0; VGA_x = '0; VGA_y = '0; VGA_Colour = '0; fb_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", int'(ready), 1);
        check("reset_count", int'(count), 0);
        check("reset_idle", int'(idle), 1);
        check("reset_we", int'(fb_we), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single plot: latency and address.
        send(5, 3, 5);
        check("single_we_early", int'(fb_we), 0);
        check("single_count", int'(count), 1);
        check("single_idle_busy", int'(idle), 0);
        @(negedge clk);
        check("single_we", int'(fb_we), 1);
        check("single_addr", int'(fb_addr), 485);
        check("single_data", int'(fb_data), 5);
        @(negedge clk);
        check("single_idle_back", int'(idle), 1);
        check("single_we_drop", int'(fb_we), 0);

        // Full-screen sweep in raster order.
        writes = 0;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                if (!ready) ready_drops++;
                send(x, y, 0);
                if (count > 1) ready_drops++;
            end
        end
        wait_drain("sweep_drain");
        check("sweep_writes", writes, 19200);
        check("sweep_last_addr", int'(last_addr), 19199);
        check("sweep_ready_drops", ready_drops, 0);

        // Backpressure: 10 plots with the RAM stalled.
        fb_busy = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) send(i, 10, i % 8);
            end
            begin
                repeat (12) @(negedge clk);
                check("bp_count_full", int'(count), 8);
                check("bp_ready_low", int'(ready), 0);
                check("bp_no_write", int'(fb_we), 0);
                fb_busy = 1'b0;
            end
        join
        wait_drain("bp_drain");
        check("bp_count_zero", int'(count), 0);

        // Off-screen requests are rejected.
        rejects = 0;
        writes  = 0;
        send(160, 0, 1);
        check("rej1_pulse", int'(reject), 1);
        send(0, 120, 2);
        check("rej2_pulse", int'(reject), 1);
        send(255, 127, 3);
        check("rej3_pulse", int'(reject), 1);
        check("rej_count", int'(count), 0);
        @(negedge clk);
        check("rej_pulse_end", int'(reject), 0);
        check("rej_total", rejects, 3);
        check("rej_no_write", writes, 0);
        send(159, 119, 6);
        wait_drain("corner_drain");
        check("corner_addr", int'(last_addr), 19199);

        // Simultaneous push/pop holding count at 3.
        fb_busy = 1'b1;
        send(1, 1, 1);
        send(2, 1, 2);
        send(3, 1, 3);
        check("pp_count_start", int'(count), 3);
        fb_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(10 + i, 50, 4);
            check("pp_count_hold", int'(count), 3);
        end
        wait_drain("pp_drain");

        // Asynchronous reset mid-operation.
        fb_busy = 1'b1;
        for (int i = 0; i < 6; i++) send(20 + i, 60, 7);
        fb_busy = 1'b0;
        @(negedge clk);
        fb_busy = 1'b1;
        check("pre_rst_count", int'(count), 5);
        check("pre_rst_we", int'(fb_we), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_we", int'(fb_we), 0);
        check("arst_count", int'(count), 0);
        check("arst_ready", int'(ready), 1);
        check("arst_idle", int'(idle), 1);
        check("arst_addr", int'(fb_addr), 0);
        check("arst_data", int'(fb_data), 0);
        check("arst_reject", int'(reject), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        fb_busy = 1'b0;
        writes = 0;
        repeat (10) @(negedge clk);
        check("post_rst_no_write", writes, 0);
        check("post_rst_count", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
